// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO: numbers each committed instruction, buffers the records
// in a show-ahead FIFO and drains them over a valid/ready trace port. It also
// keeps cycle, instruction and drop statistics and reports when the halt has
// been seen and the FIFO has fully drained.
module commit_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cm_valid,
    input  logic [15:0] cm_pc,
    input  logic [15:0] cm_inst,
    input  logic        cm_regwrite,
    input  logic [2:0]  cm_wreg,
    input  logic [15:0] cm_wdata,
    input  logic        cm_memread,
    input  logic        cm_memwrite,
    input  logic [15:0] cm_addr,
    input  logic [15:0] cm_mdata,
    input  logic        cm_halt,
    input  logic        tr_ready,
    output logic        tr_valid,
    output logic [15:0] tr_inum,
    output logic [15:0] tr_pc,
    output logic [15:0] tr_inst,
    output logic [2:0]  tr_wreg,
    output logic [15:0] tr_wdata,
    output logic [15:0] tr_addr,
    output logic [15:0] tr_mdata,
    output logic [3:0]  tr_flags,
    output logic [31:0] cycle_count,
    output logic [15:0] inst_count,
    output logic [7:0]  drop_count,
    output logic        overflow,
    output logic        done
);

    // Record layout: {inum, pc, inst, wreg, wdata, addr, mdata, flags}
    localparam int RW = 103;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTING = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic [RW-1:0]  mem_r [DEPTH];
    logic [AW:0]    wr_ptr_r;
    logic [AW:0]    rd_ptr_r;
    logic [AW:0]    count_s;
    logic [31:0]    cycle_count_r;
    logic [15:0]    inst_count_r;
    logic [7:0]     drop_count_r;
    logic           overflow_r;
    logic           done_r;
    logic           empty_s;
    logic           full_s;
    logic           pop_s;
    logic           commit_s;
    logic           slot_s;
    logic           push_s;
    logic           drop_s;
    logic           drain_done_s;
    logic [RW-1:0]  wr_rec_s;
    logic [RW-1:0]  head_s;

    // FIFO status and push/pop/drop decisions for this cycle
    always_comb begin
        empty_s      = (wr_ptr_r == rd_ptr_r);
        full_s       = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_s        = !empty_s && tr_ready;
        commit_s     = (state_r == ST_RUN) && cm_valid;
        // A full FIFO still takes a record when the head leaves this cycle
        slot_s       = !full_s || pop_s;
        push_s       = commit_s && slot_s;
        drop_s       = commit_s && !slot_s;
        count_s      = wr_ptr_r - rd_ptr_r;
        drain_done_s = empty_s || ((count_s == PTR_ONE) && pop_s);
        wr_rec_s     = {inst_count_r, cm_pc, cm_inst, cm_wreg, cm_wdata,
                        cm_addr, cm_mdata,
                        cm_halt, cm_memread, cm_memwrite, cm_regwrite};
    end

    // Next-state logic for the run / halting / done sequence
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (commit_s && cm_halt) begin
                    state_next_s = ST_HALTING;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALTING: begin
                if (drain_done_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_HALTING;
                end
            end
            ST_DONE: begin
                state_next_s = ST_DONE;
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // Record storage; contents are left alone by reset since pointers decide validity
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_rec_s;
        end
    end

    // State, pointers and statistics counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= ST_RUN;
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            cycle_count_r <= 32'd0;
            inst_count_r  <= 16'd0;
            drop_count_r  <= 8'd0;
            overflow_r    <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            // Dropped commits are still numbered so the sink can see the gap
            if (commit_s) begin
                inst_count_r <= inst_count_r + 16'd1;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_count_r != 8'hFF) begin
                    drop_count_r <= drop_count_r + 8'd1;
                end
            end
            if (state_r != ST_DONE) begin
                cycle_count_r <= cycle_count_r + 32'd1;
            end
            done_r <= (state_next_s == ST_DONE);
        end
    end

    // Show-ahead head record
    assign head_s      = mem_r[rd_ptr_r[AW-1:0]];
    assign tr_valid    = !empty_s;
    assign tr_inum     = head_s[102:87];
    assign tr_pc       = head_s[86:71];
    assign tr_inst     = head_s[70:55];
    assign tr_wreg     = head_s[54:52];
    assign tr_wdata    = head_s[51:36];
    assign tr_addr     = head_s[35:20];
    assign tr_mdata    = head_s[19:4];
    assign tr_flags    = head_s[3:0];
    assign cycle_count = cycle_count_r;
    assign inst_count  = inst_count_r;
    assign drop_count  = drop_count_r;
    assign overflow    = overflow_r;
    assign done        = done_r;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed bench for commit_trace_fifo with hand-computed expectations.
module tb_commit_trace_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        cm_valid;
    logic [15:0] cm_pc;
    logic [15:0] cm_inst;
    logic        cm_regwrite;
    logic [2:0]  cm_wreg;
    logic [15:0] cm_wdata;
    logic        cm_memread;
    logic        cm_memwrite;
    logic [15:0] cm_addr;
    logic [15:0] cm_mdata;
    logic        cm_halt;
    logic        tr_ready;
    logic        tr_valid;
    logic [15:0] tr_inum;
    logic [15:0] tr_pc;
    logic [15:0] tr_inst;
    logic [2:0]  tr_wreg;
    logic [15:0] tr_wdata;
    logic [15:0] tr_addr;
    logic [15:0] tr_mdata;
    logic [3:0]  tr_flags;
    logic [31:0] cycle_count;
    logic [15:0] inst_count;
    logic [7:0]  drop_count;
    logic        overflow;
    logic        done;

    int check_count = 0;
    int error_count = 0;

    commit_trace_fifo #(.DEPTH(8), .AW(3)) dut (
        .clk(clk), .rst(rst),
        .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_inst(cm_inst),
        .cm_regwrite(cm_regwrite), .cm_wreg(cm_wreg), .cm_wdata(cm_wdata),
        .cm_memread(cm_memread), .cm_memwrite(cm_memwrite),
        .cm_addr(cm_addr), .cm_mdata(cm_mdata), .cm_halt(cm_halt),
        .tr_ready(tr_ready), .tr_valid(tr_valid), .tr_inum(tr_inum),
        .tr_pc(tr_pc), .tr_inst(tr_inst), .tr_wreg(tr_wreg),
        .tr_wdata(tr_wdata), .tr_addr(tr_addr), .tr_mdata(tr_mdata),
        .tr_flags(tr_flags), .cycle_count(cycle_count),
        .inst_count(inst_count), .drop_count(drop_count),
        .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] pc, input logic [15:0] inst,
                         input logic rw, input logic [2:0] wreg, input logic [15:0] wdata,
                         input logic mr, input logic mw, input logic [15:0] addr,
                         input logic [15:0] mdata, input logic halt);
        cm_valid    = 1'b1;
        cm_pc       = pc;
        cm_inst     = inst;
        cm_regwrite = rw;
        cm_wreg     = wreg;
        cm_wdata    = wdata;
        cm_memread  = mr;
        cm_memwrite = mw;
        cm_addr     = addr;
        cm_mdata    = mdata;
        cm_halt     = halt;
    endtask

    task automatic idle();
        cm_valid = 1'b0;
        cm_halt  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Simple commit: pc, inst = 0x1000+n, regwrite r1 = 0x0011
    task automatic simple_commit(input int n, input logic [15:0] pc);
        drive(pc, 16'h1000 + 16'(n), 1'b1, 3'd1, 16'h0011, 1'b0, 1'b0,
              16'h0000, 16'h0000, 1'b0);
    endtask

    logic [31:0] frozen_cycles;

    initial begin
        rst = 1'b0;
        tr_ready = 1'b0;
        idle();
        cm_pc = 16'h0; cm_inst = 16'h0; cm_regwrite = 1'b0; cm_wreg = 3'd0;
        cm_wdata = 16'h0; cm_memread = 1'b0; cm_memwrite = 1'b0;
        cm_addr = 16'h0; cm_mdata = 16'h0;

        // Test 1: reset state and basic streaming
        do_reset();
        check_eq("rst_valid", 32'(tr_valid), 32'd0);
        check_eq("rst_cycles", cycle_count, 32'd0);
        check_eq("rst_icount", 32'(inst_count), 32'd0);
        check_eq("rst_drops", 32'(drop_count), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        tr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            simple_commit(i, 16'(2 * i));
            tick();
            check_eq("t1_valid", 32'(tr_valid), 32'd1);
            check_eq("t1_inum", 32'(tr_inum), 32'(i));
            check_eq("t1_pc", 32'(tr_pc), 32'(2 * i));
            check_eq("t1_wreg", 32'(tr_wreg), 32'd1);
            check_eq("t1_wdata", 32'(tr_wdata), 32'h0011);
            check_eq("t1_flags", 32'(tr_flags), 32'b0001);
        end
        idle();
        tick();
        check_eq("t1_empty", 32'(tr_valid), 32'd0);
        check_eq("t1_icount", 32'(inst_count), 32'd3);

        // Test 2: overflow with the sink stalled, then drain
        do_reset();
        tr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            simple_commit(i, 16'h0100 + 16'(2 * i));
            tick();
        end
        idle();
        check_eq("t2_ovf", 32'(overflow), 32'd1);
        check_eq("t2_drops", 32'(drop_count), 32'd2);
        check_eq("t2_icount", 32'(inst_count), 32'd10);
        tr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("t2_valid", 32'(tr_valid), 32'd1);
            check_eq("t2_inum", 32'(tr_inum), 32'(i));
            check_eq("t2_pc", 32'(tr_pc), 32'h0100 + 32'(2 * i));
            tick();
        end
        check_eq("t2_empty", 32'(tr_valid), 32'd0);
        check_eq("t2_ovf_sticky", 32'(overflow), 32'd1);

        // Test 3: push into a full FIFO while the head pops
        do_reset();
        tr_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            simple_commit(i, 16'h0200 + 16'(2 * i));
            tick();
        end
        tr_ready = 1'b1;
        simple_commit(8, 16'h0210);
        tick();
        idle();
        tr_ready = 1'b0;
        check_eq("t3_ovf", 32'(overflow), 32'd0);
        check_eq("t3_drops", 32'(drop_count), 32'd0);
        check_eq("t3_icount", 32'(inst_count), 32'd9);
        tr_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            check_eq("t3_inum", 32'(tr_inum), 32'(i));
            check_eq("t3_valid", 32'(tr_valid), 32'd1);
            tick();
        end
        check_eq("t3_empty", 32'(tr_valid), 32'd0);

        // Test 4: halt, ignored commits, drain to done, frozen cycle counter
        do_reset();
        tr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            simple_commit(i, 16'(2 * i));
            tick();
        end
        drive(16'h0010, 16'hF000, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        tick();
        simple_commit(4, 16'h0012);
        tick();
        simple_commit(5, 16'h0014);
        tick();
        idle();
        check_eq("t4_icount", 32'(inst_count), 32'd4);
        check_eq("t4_drops", 32'(drop_count), 32'd0);
        tr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("t4_inum", 32'(tr_inum), 32'(i));
            check_eq("t4_done_early", 32'(done), 32'd0);
            if (i == 3) begin
                check_eq("t4_halt_flags", 32'(tr_flags), 32'b1000);
                check_eq("t4_halt_pc", 32'(tr_pc), 32'h0010);
            end
            tick();
        end
        check_eq("t4_empty", 32'(tr_valid), 32'd0);
        check_eq("t4_done", 32'(done), 32'd1);
        check_eq("t4_cycles", cycle_count, 32'd10);
        frozen_cycles = cycle_count;
        tick();
        tick();
        tick();
        check_eq("t4_frozen", cycle_count, frozen_cycles);
        check_eq("t4_done_hold", 32'(done), 32'd1);

        // Test 5: reset while entries are queued
        do_reset();
        tr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            simple_commit(i, 16'h0300 + 16'(2 * i));
            tick();
        end
        idle();
        rst = 1'b0;
        tick();
        check_eq("t5_valid", 32'(tr_valid), 32'd0);
        check_eq("t5_icount", 32'(inst_count), 32'd0);
        check_eq("t5_cycles", cycle_count, 32'd0);
        check_eq("t5_done", 32'(done), 32'd0);
        rst = 1'b1;
        simple_commit(0, 16'h0400);
        tick();
        idle();
        check_eq("t5_run_valid", 32'(tr_valid), 32'd1);
        check_eq("t5_run_inum", 32'(tr_inum), 32'd0);
        check_eq("t5_run_pc", 32'(tr_pc), 32'h0400);

        // Test 6: streaming 20 records across pointer wrap
        do_reset();
        tr_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(16'h0500 + 16'(2 * i), 16'hA000 + 16'(i), 1'b1, 3'(i % 8),
                  16'hB000 + 16'(i), (i % 3) == 0, (i % 2) == 1,
                  16'hC000 + 16'(i), 16'hD000 + 16'(i), 1'b0);
            tick();
            check_eq("t6_inum", 32'(tr_inum), 32'(i));
            check_eq("t6_pc", 32'(tr_pc), 32'h0500 + 32'(2 * i));
            check_eq("t6_inst", 32'(tr_inst), 32'hA000 + 32'(i));
            check_eq("t6_wreg", 32'(tr_wreg), 32'(i % 8));
            check_eq("t6_wdata", 32'(tr_wdata), 32'hB000 + 32'(i));
            check_eq("t6_addr", 32'(tr_addr), 32'hC000 + 32'(i));
            check_eq("t6_mdata", 32'(tr_mdata), 32'hD000 + 32'(i));
            check_eq("t6_flags", 32'(tr_flags),
                     {28'd0, 1'b0, 1'((i % 3) == 0), 1'((i % 2) == 1), 1'b1});
        end
        idle();
        tick();
        check_eq("t6_empty", 32'(tr_valid), 32'd0);
        check_eq("t6_icount", 32'(inst_count), 32'd20);
        check_eq("t6_ovf", 32'(overflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
